oq_ingress_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing the single write port of output_queue_v0_1_with_cpu among
//  NUM_PORTS AXI-Stream ingress sources. Drives the tvalid/tlast/tdata/tkeep/tuser/tpifo, buffer_wr_en
//  and pifo_insert_en inputs of the output queue. Admits a new packet only when buffer and PIFO are not full.

---
 rtl/oq_arb_pkg.sv | 13 +
 rtl/oq_rr_pick.sv | 28 ++
 rtl/oq_ingress_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_oq_ingress_rr_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oq_arb_pkg.sv
// rtl/oq_arb_pkg.sv - shared defaults and FSM state type for the output-queue ingress arbiter
package oq_arb_pkg;

  localparam int DATA_WIDTH_DEF  = 256;
  localparam int TUSER_WIDTH_DEF = 128;
  localparam int TPIFO_WIDTH_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/oq_rr_pick.sv
// rtl/oq_rr_pick.sv - combinational rotate-priority encoder: first requester at or above ptr, wrapping
module oq_rr_pick #(
  parameter  int NUM_PORTS = 4,
  localparam int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [ID_W-1:0]      i_ptr,
  output logic [ID_W-1:0]      o_gnt_id,
  output logic                 o_gnt_vld
);

  logic [ID_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester is the last one assigned.
  always_comb begin
    o_gnt_id  = '0;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_idx = ID_W'((32'(i_ptr) + 32'(i)) % 32'(NUM_PORTS));
      if (i_req[w_idx]) begin
        o_gnt_id  = w_idx;
        o_gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oq_ingress_rr_arbiter.sv
// rtl/oq_ingress_rr_arbiter.sv - packet-granular round-robin arbiter feeding the output-queue write port
// Optional per-port packet counters when OQ_ARB_PKT_CNT_EN is defined.
module oq_ingress_rr_arbiter
  import oq_arb_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int TUSER_WIDTH = TUSER_WIDTH_DEF,
  parameter  int TPIFO_WIDTH = TPIFO_WIDTH_DEF,
  localparam int ID_W        = $clog2(NUM_PORTS),
  localparam int KEEP_W      = DATA_WIDTH / 8
) (
  input  logic                             axis_aclk,
  input  logic                             axis_reset,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0]      s_axis_tkeep,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS*TPIFO_WIDTH-1:0] s_axis_tpifo,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_W-1:0]                m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic [TPIFO_WIDTH-1:0]           m_axis_tpifo,
  output logic                             m_axis_buffer_wr_en,
  output logic                             m_axis_pifo_insert_en,
  output logic [ID_W-1:0]                  m_grant_id,
`ifdef OQ_ARB_PKT_CNT_EN
  output logic [NUM_PORTS*32-1:0]          m_pkt_count,
`endif
  input  logic                             i_buffer_almost_full,
  input  logic                             i_pifo_full
);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_grant;
  logic             r_first;

  logic [ID_W-1:0]        w_pick_id;
  logic                   w_pick_vld;
  logic                   w_admit;
  logic                   w_accept;
  logic                   w_sel_last;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [KEEP_W-1:0]      w_sel_keep;
  logic [TUSER_WIDTH-1:0] w_sel_user;
  logic [TPIFO_WIDTH-1:0] w_sel_pifo;
  logic [ID_W-1:0]        w_ptr_next;

  oq_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .i_req     (s_axis_tvalid),
    .i_ptr     (r_ptr),
    .o_gnt_id  (w_pick_id),
    .o_gnt_vld (w_pick_vld)
  );

  // Full flags only gate admission; an in-flight packet relies on almost-full headroom.
  assign w_admit    = (r_state == IDLE) && w_pick_vld && !i_buffer_almost_full && !i_pifo_full;
  assign w_accept   = (r_state == XFER) && s_axis_tvalid[r_grant];
  assign w_sel_last = s_axis_tlast[r_grant];
  assign w_sel_data = s_axis_tdata[32'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_keep = s_axis_tkeep[32'(r_grant)*KEEP_W +: KEEP_W];
  assign w_sel_user = s_axis_tuser[32'(r_grant)*TUSER_WIDTH +: TUSER_WIDTH];
  assign w_sel_pifo = s_axis_tpifo[32'(r_grant)*TPIFO_WIDTH +: TPIFO_WIDTH];
  assign w_ptr_next = (r_grant == ID_W'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    s_axis_tready = '0;
    if (r_state == XFER) s_axis_tready[r_grant] = 1'b1;
  end

  assign m_grant_id          = r_grant;
  assign m_axis_buffer_wr_en = m_axis_tvalid;

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state               <= IDLE;
      r_ptr                 <= '0;
      r_grant               <= '0;
      r_first               <= 1'b0;
      m_axis_tvalid         <= 1'b0;
      m_axis_tlast          <= 1'b0;
      m_axis_tdata          <= '0;
      m_axis_tkeep          <= '0;
      m_axis_tuser          <= '0;
      m_axis_tpifo          <= '0;
      m_axis_pifo_insert_en <= 1'b0;
    end else begin
      m_axis_tvalid         <= w_accept;
      m_axis_pifo_insert_en <= w_accept && r_first;
      if (w_accept) begin
        m_axis_tlast <= w_sel_last;
        m_axis_tdata <= w_sel_data;
        m_axis_tkeep <= w_sel_keep;
        m_axis_tuser <= w_sel_user;
        if (r_first) m_axis_tpifo <= w_sel_pifo;
      end

      case (r_state)
        IDLE: begin
          if (w_admit) begin
            r_grant <= w_pick_id;
            r_first <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_accept) begin
            r_first <= 1'b0;
            if (w_sel_last) begin
              r_ptr   <= w_ptr_next;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef OQ_ARB_PKT_CNT_EN
  logic [31:0] r_pkt_cnt [NUM_PORTS];

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      for (int k = 0; k < NUM_PORTS; k++) r_pkt_cnt[k] <= '0;
    end else if (w_accept && w_sel_last) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign m_pkt_count[g*32 +: 32] = r_pkt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_oq_ingress_rr_arbiter.sv
// tb/tb_oq_ingress_rr_arbiter.sv - scoreboard bench for the output-queue ingress round-robin arbiter
module tb_oq_ingress_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int PW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic [PW-1:0] pifo;
    logic          last;
    logic          first;
    logic [1:0]    port;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          tb_valid [NP];
  logic          tb_last  [NP];
  logic [DW-1:0] tb_data  [NP];
  logic [KW-1:0] tb_keep  [NP];
  logic [UW-1:0] tb_user  [NP];
  logic [PW-1:0] tb_pifo  [NP];

  logic [NP-1:0]    s_tvalid, s_tready, s_tlast;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP*UW-1:0] s_tuser;
  logic [NP*PW-1:0] s_tpifo;
  logic             m_tvalid, m_tlast, m_wr_en, m_pifo_en;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [UW-1:0]    m_tuser;
  logic [PW-1:0]    m_tpifo;
  logic [1:0]       m_grant_id;
  logic             af = 1'b0;
  logic             pf = 1'b0;
`ifdef OQ_ARB_PKT_CNT_EN
  logic [NP*32-1:0] m_pkt_count;
`endif

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign s_tvalid[g]            = tb_valid[g];
    assign s_tlast[g]             = tb_last[g];
    assign s_tdata[g*DW +: DW]    = tb_data[g];
    assign s_tkeep[g*KW +: KW]    = tb_keep[g];
    assign s_tuser[g*UW +: UW]    = tb_user[g];
    assign s_tpifo[g*PW +: PW]    = tb_pifo[g];
  end

  oq_ingress_rr_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .TPIFO_WIDTH(PW)
  ) dut (
    .axis_aclk             (clk),
    .axis_reset            (rst),
    .s_axis_tvalid         (s_tvalid),
    .s_axis_tready         (s_tready),
    .s_axis_tlast          (s_tlast),
    .s_axis_tdata          (s_tdata),
    .s_axis_tkeep          (s_tkeep),
    .s_axis_tuser          (s_tuser),
    .s_axis_tpifo          (s_tpifo),
    .m_axis_tvalid         (m_tvalid),
    .m_axis_tlast          (m_tlast),
    .m_axis_tdata          (m_tdata),
    .m_axis_tkeep          (m_tkeep),
    .m_axis_tuser          (m_tuser),
    .m_axis_tpifo          (m_tpifo),
    .m_axis_buffer_wr_en   (m_wr_en),
    .m_axis_pifo_insert_en (m_pifo_en),
    .m_grant_id            (m_grant_id),
`ifdef OQ_ARB_PKT_CNT_EN
    .m_pkt_count           (m_pkt_count),
`endif
    .i_buffer_almost_full  (af),
    .i_pifo_full           (pf)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  beat_t sb_q[$];
  int    first_cyc_q[$];
  int    first_port_q[$];
  int    exp_cnt [NP];
  beat_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mk_data(int p, int pkt, int b);
    return {8{8'hA5, 8'(p), 8'(pkt), 8'(b)}};
  endfunction
  function automatic logic [KW-1:0] mk_keep(int p, int pkt, int b);
    return {8'(b), 8'(pkt), 8'(p), 8'h5A};
  endfunction
  function automatic logic [UW-1:0] mk_user(int p, int pkt, int b);
    return {4{8'(p), 8'(b), 8'(pkt), 8'hC3}};
  endfunction

  // Output monitor: every forwarded beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && m_tvalid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_beat: got beat from id=%0d data=%h, required no beat", m_grant_id, m_tdata);
      end else begin
        mon_e = sb_q.pop_front();
        if ({m_tdata, m_tkeep, m_tuser, m_tpifo, m_tlast, m_pifo_en, m_grant_id, m_wr_en} !==
            {mon_e.data, mon_e.keep, mon_e.user, mon_e.pifo, mon_e.last, mon_e.first, mon_e.port, 1'b1}) begin
          n_fail++;
          $display("FAIL sb_beat: got data=%h keep=%h user=%h pifo=%h last=%b ins=%b id=%0d wr=%b, required data=%h keep=%h user=%h pifo=%h last=%b ins=%b id=%0d wr=1",
                   m_tdata, m_tkeep, m_tuser, m_tpifo, m_tlast, m_pifo_en, m_grant_id, m_wr_en,
                   mon_e.data, mon_e.keep, mon_e.user, mon_e.pifo, mon_e.last, mon_e.first, mon_e.port);
        end
      end
    end
    if (!rst && m_pifo_en) begin
      first_cyc_q.push_back(cyc);
      first_port_q.push_back(int'(m_grant_id));
    end
  end

  task automatic drive_pkt(input int p, input int nb, input logic [31:0] pifo, input int pkt);
    beat_t e;
    int    budget;
    for (int b = 0; b < nb; b++) begin
      tb_valid[p] = 1'b1;
      tb_last[p]  = (b == nb - 1);
      tb_data[p]  = mk_data(p, pkt, b);
      tb_keep[p]  = mk_keep(p, pkt, b);
      tb_user[p]  = mk_user(p, pkt, b);
      tb_pifo[p]  = (b == 0) ? pifo : (32'hDEAD_0000 | 32'(b));
      budget = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          tb_valid[p] = 1'b0;
          tb_last[p]  = 1'b0;
          return;
        end
        if (s_tready[p]) break;
        budget++;
        if (budget > 300) begin
          n_checks++;
          n_fail++;
          $display("FAIL tready_timeout port%0d: got no tready in 300 cycles, required a grant", p);
          tb_valid[p] = 1'b0;
          tb_last[p]  = 1'b0;
          return;
        end
      end
      e.data  = tb_data[p];
      e.keep  = tb_keep[p];
      e.user  = tb_user[p];
      e.pifo  = pifo;
      e.last  = tb_last[p];
      e.first = (b == 0);
      e.port  = 2'(p);
      sb_q.push_back(e);
      if (b == nb - 1) exp_cnt[p]++;
      @(posedge clk);
      #1;
    end
    tb_valid[p] = 1'b0;
    tb_last[p]  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sb_q.delete();
    first_cyc_q.delete();
    first_port_q.delete();
    for (int i = 0; i < NP; i++) exp_cnt[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ((|{s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tpifo, m_wr_en, m_pifo_en, m_grant_id}) !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tready=%b tvalid=%b last=%b data=%h pifo=%h ins=%b id=%0d, required all 0",
               s_tready, m_tvalid, m_tlast, m_tdata, m_tpifo, m_pifo_en, m_grant_id);
    end
`ifdef OQ_ARB_PKT_CNT_EN
    n_checks++;
    if (m_pkt_count !== '0) begin
      n_fail++;
      $display("FAIL reset_pkt_count: got %h, required 0", m_pkt_count);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_packet();
    int k;
    fork
      drive_pkt(0, 3, 32'h10, 1);
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!s_tready[0] && k < 300);
        n_checks++;
        if (m_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL latency_before: got m_tvalid=%b in accept cycle, required 0", m_tvalid);
        end
        @(negedge clk);
        n_checks++;
        if ({m_tvalid, m_pifo_en, m_tpifo} !== {1'b1, 1'b1, 32'h10}) begin
          n_fail++;
          $display("FAIL latency_first_beat: got tvalid=%b ins=%b pifo=%h, required 1 1 00000010", m_tvalid, m_pifo_en, m_tpifo);
        end
      end
    join
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_packet_drain: got %0d beats outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    first_cyc_q.delete();
    first_port_q.delete();
    fork
      begin
        drive_pkt(0, 2, 32'h20, 20);
        drive_pkt(0, 2, 32'h24, 24);
      end
      drive_pkt(1, 2, 32'h21, 21);
      drive_pkt(2, 2, 32'h22, 22);
      drive_pkt(3, 2, 32'h23, 23);
    join
    repeat (3) @(negedge clk);
    n_checks++;
    if (first_port_q.size() != 5 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d packets and %0d beats outstanding, required 5 and 0", first_port_q.size(), sb_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (first_port_q[i] != exp_order[i]) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: got port %0d, required %0d", i, first_port_q[i], exp_order[i]);
        end
        if (i > 0) begin
          n_checks++;
          if (first_cyc_q[i] - first_cyc_q[i-1] != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 3", i, first_cyc_q[i] - first_cyc_q[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_almost_full();
    af = 1'b1;
    fork
      drive_pkt(1, 2, 32'h31, 31);
      begin
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if ({s_tready, m_tvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL almost_full_hold: got tready=%b tvalid=%b, required 0000 0", s_tready, m_tvalid);
          end
        end
        @(posedge clk);
        #1 af = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s_tready !== 4'b0010) begin
          n_fail++;
          $display("FAIL almost_full_release: got tready=%b, required 0010", s_tready);
        end
      end
    join
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL almost_full_drain: got %0d beats outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_pifo_full_mid_packet();
    int k;
    fork
      drive_pkt(3, 4, 32'h43, 43);
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!s_tready[3] && k < 300);
        @(posedge clk);
        #1 pf = 1'b1;
      end
    join
    fork
      drive_pkt(0, 1, 32'h40, 40);
      begin
        repeat (4) begin
          @(negedge clk);
          n_checks++;
          if (s_tready !== 4'b0000) begin
            n_fail++;
            $display("FAIL pifo_full_hold: got tready=%b, required 0000", s_tready);
          end
        end
        @(posedge clk);
        #1 pf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s_tready !== 4'b0001) begin
          n_fail++;
          $display("FAIL pifo_full_release: got tready=%b, required 0001", s_tready);
        end
      end
    join
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL pifo_full_drain: got %0d beats outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_single_beat();
    drive_pkt(2, 1, 32'h52, 52);
    @(negedge clk);
    n_checks++;
    if ({m_tvalid, m_tlast, m_pifo_en, m_grant_id} !== {3'b111, 2'd2}) begin
      n_fail++;
      $display("FAIL single_beat: got tvalid=%b last=%b ins=%b id=%0d, required 1 1 1 2", m_tvalid, m_tlast, m_pifo_en, m_grant_id);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    int k;
    fork
      drive_pkt(0, 5, 32'h60, 60);
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!s_tready[0] && k < 300);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ((|{s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tpifo, m_wr_en, m_pifo_en, m_grant_id}) !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_packet: got tready=%b tvalid=%b last=%b data=%h pifo=%h ins=%b id=%0d, required all 0",
                   s_tready, m_tvalid, m_tlast, m_tdata, m_tpifo, m_pifo_en, m_grant_id);
        end
        n_checks++;
        if (sb_q.size() != 1) begin
          n_fail++;
          $display("FAIL reset_dropped_beats: got %0d beats outstanding, required 1", sb_q.size());
        end
        sb_q.delete();
        for (int i = 0; i < NP; i++) exp_cnt[i] = 0;
`ifdef OQ_ARB_PKT_CNT_EN
        n_checks++;
        if (m_pkt_count !== '0) begin
          n_fail++;
          $display("FAIL reset_mid_pkt_count: got %h, required 0", m_pkt_count);
        end
`endif
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    first_port_q.delete();
    first_cyc_q.delete();
    fork
      drive_pkt(2, 1, 32'h62, 62);
      drive_pkt(0, 1, 32'h61, 61);
    join
    repeat (3) @(negedge clk);
    n_checks++;
    if (first_port_q.size() != 2 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d packets, %0d beats outstanding, required 2 and 0", first_port_q.size(), sb_q.size());
    end else if (first_port_q[0] != 0 || first_port_q[1] != 2) begin
      n_fail++;
      $display("FAIL post_reset_ptr: got order %0d,%0d, required 0,2", first_port_q[0], first_port_q[1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NP; i++) begin
      tb_valid[i] = 1'b0;
      tb_last[i]  = 1'b0;
      tb_data[i]  = '0;
      tb_keep[i]  = '0;
      tb_user[i]  = '0;
      tb_pifo[i]  = '0;
      exp_cnt[i]  = 0;
    end
    test_reset();
    test_single_packet();
    test_reset();
    test_back_to_back();
    test_almost_full();
    test_pifo_full_mid_packet();
    test_single_beat();
    test_reset_mid_packet();
`ifdef OQ_ARB_PKT_CNT_EN
    for (int i = 0; i < NP; i++) begin
      n_checks++;
      if (m_pkt_count[i*32 +: 32] !== 32'(exp_cnt[i])) begin
        n_fail++;
        $display("FAIL pkt_count[%0d]: got %0d, required %0d", i, m_pkt_count[i*32 +: 32], exp_cnt[i]);
      end
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
